// File: rtl/rr_decoder_arbiter_pkg.sv
// rtl/rr_decoder_arbiter_pkg.sv - shared types and constants for the round-robin decoder arbiter
package rr_decoder_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] addr_to_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_REQ-1:0] base;
        base = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return base << addr;
    endfunction

endpackage

// File: rtl/rr_decoder_arbiter_rr_pick.sv
// rtl/rr_decoder_arbiter_rr_pick.sv - combinational rotate-priority encoder starting after last_owner
module rr_pick
    import rr_decoder_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ADDR_W-1:0]  last_owner,
    output logic [ADDR_W-1:0]  pick,
    output logic               any
);

    logic [ADDR_W-1:0] idx;

    // Walk from lowest to highest priority so the nearest requester after last_owner wins.
    always_comb begin
        pick = last_owner;
        any  = 1'b0;
        idx  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = last_owner + ADDR_W'(i);
            if (req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/structuralDecoder.sv
// rtl/structuralDecoder.sv - gate-level 2-to-4 decoder with enable
module structuralDecoder (
    input  logic       address0,
    input  logic       address1,
    input  logic       enable,
    output logic [3:0] out
);

    logic a0_n;
    logic a1_n;

    not g_inv0 (a0_n, address0);
    not g_inv1 (a1_n, address1);

    and g_out0 (out[0], enable, a1_n,     a0_n);
    and g_out1 (out[1], enable, a1_n,     address0);
    and g_out2 (out[2], enable, address1, a0_n);
    and g_out3 (out[3], enable, address1, address0);

endmodule

// File: rtl/rr_decoder_arbiter.sv
// rtl/rr_decoder_arbiter.sv - four-way round-robin arbiter with bounded hold, one-hot grant via 2-to-4 decoder
module rr_decoder_arbiter
    import rr_decoder_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ADDR_W-1:0]  grant_addr,
    output logic               grant_valid,
    output logic               preempt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] grant_addr_q, grant_addr_d;
    logic              grant_valid_q, grant_valid_d;
    logic [ADDR_W-1:0] last_owner_q, last_owner_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic              preempt_q, preempt_d;

    logic [ADDR_W-1:0] pick;
    logic              any;
    logic              owner_req;
    logic              others_req;

    rr_pick u_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .pick       (pick),
        .any        (any)
    );

    // While BUSY last_owner equals the owner, so the pick naturally ranks the owner last.
    assign owner_req  = req[grant_addr_q];
    assign others_req = |(req & ~addr_to_onehot(grant_addr_q));

    always_comb begin
        state_d       = state_q;
        grant_addr_d  = grant_addr_q;
        grant_valid_d = grant_valid_q;
        last_owner_d  = last_owner_q;
        hold_cnt_d    = hold_cnt_q;
        preempt_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && any) begin
                    state_d       = BUSY;
                    grant_addr_d  = pick;
                    grant_valid_d = 1'b1;
                    last_owner_d  = pick;
                    hold_cnt_d    = '0;
                end
            end
            BUSY: begin
                if (!enable) begin
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                end else if (!owner_req) begin
                    hold_cnt_d = '0;
                    if (any) begin
                        grant_addr_d = pick;
                        last_owner_d = pick;
                    end else begin
                        state_d       = IDLE;
                        grant_valid_d = 1'b0;
                    end
                end else if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    if (others_req) begin
                        grant_addr_d = pick;
                        last_owner_d = pick;
                        preempt_d    = 1'b1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_addr_q  <= '0;
            grant_valid_q <= 1'b0;
            last_owner_q  <= ADDR_W'(NUM_REQ - 1);
            hold_cnt_q    <= '0;
            preempt_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_addr_q  <= grant_addr_d;
            grant_valid_q <= grant_valid_d;
            last_owner_q  <= last_owner_d;
            hold_cnt_q    <= hold_cnt_d;
            preempt_q     <= preempt_d;
        end
    end

    structuralDecoder u_dec (
        .address0 (grant_addr_q[0]),
        .address1 (grant_addr_q[1]),
        .enable   (grant_valid_q),
        .out      (grant)
    );

    assign grant_addr  = grant_addr_q;
    assign grant_valid = grant_valid_q;
    assign preempt     = preempt_q;

endmodule
